// File: rtl/bin_bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Digits needed to hold any IN_W-bit magnitude (3/10 approximates log10(2)).
  function automatic int unsigned int_digits(input int unsigned in_w);
    return (3 * in_w) / 10 + 1;
  endfunction

  // 10^n as a 64-bit constant; saturates where the result would not fit.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    if (n > 19) begin
      return '1;
    end
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: one BCD digit gets +3 when it is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_adj_c
);

  assign dig_adj_c = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (one double-dabble step per clock) with
// valid/ready handshakes, sign handling, leading-zero blanking and overflow flag.
module bin_to_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int unsigned IN_W      = 32,
  parameter int unsigned DIGITS    = 2,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValid,
  input  logic [IN_W-1:0]       iBin,
  input  logic                  iSigned,
  output logic                  oReady,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [4*DIGITS-1:0]   oDec,
  output logic [DIGITS-1:0]     oBlank,
  output logic                  oNeg,
  output logic                  oOvf
);

  localparam int unsigned INT_DIGITS = int_digits(IN_W);
  localparam int unsigned BCD_W      = 4 * INT_DIGITS;
  localparam int unsigned DEC_W      = 4 * DIGITS;
  localparam int unsigned PAD_W      = (BCD_W > DEC_W) ? BCD_W : DEC_W;
  localparam int unsigned CNT_W      = $clog2(IN_W + 1);
  localparam bit          THR_EN     = (DIGITS < INT_DIGITS);
  localparam logic [63:0] OVF_THR    = pow10(DIGITS);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_e               state_q, state_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [IN_W-1:0]      bin_q, bin_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_pend_q, neg_pend_d;
  logic                 thr_q, thr_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [DEC_W-1:0]     dec_q, dec_d;
  logic [DIGITS-1:0]    blank_q, blank_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;

  logic [BCD_W-1:0]     adj_c;
  logic                 op_neg_c;
  logic [IN_W-1:0]      op_mag_c;
  logic                 op_ge_c;
  logic                 carry_c;
  logic [BCD_W-1:0]     bcd_sh_c;
  logic [IN_W-1:0]      bin_sh_c;
  logic [PAD_W-1:0]     pad_c;
  logic [DEC_W-1:0]     dec_new_c;
  logic [DIGITS-1:0]    blank_new_c;
  logic                 upper_nz_c;
  logic                 zrun_c;
  logic                 last_c;

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .dig_i     (bcd_q[4*g +: 4]),
      .dig_adj_c (adj_c[4*g +: 4])
    );
  end

  // Operand magnitude; the most negative value negates to exactly 2^(IN_W-1).
  always_comb begin
    op_neg_c = SIGNED_EN && iSigned && iBin[IN_W-1];
    op_mag_c = op_neg_c ? (~iBin + IN_W'(1)) : iBin;
    op_ge_c  = THR_EN && (64'(op_mag_c) >= OVF_THR);
  end

  // One shift step plus the result view of the post-shift register.
  always_comb begin
    {carry_c, bcd_sh_c, bin_sh_c} = {adj_c, bin_q, 1'b0};
    pad_c      = PAD_W'(bcd_sh_c);
    dec_new_c  = pad_c[DEC_W-1:0];
    upper_nz_c = 1'b0;
    for (int unsigned g = DIGITS; g < INT_DIGITS; g++) begin
      upper_nz_c = upper_nz_c | (|pad_c[4*g +: 4]);
    end
    blank_new_c = '0;
    zrun_c      = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zrun_c         = zrun_c & (dec_new_c[4*i +: 4] == 4'd0);
      blank_new_c[i] = zrun_c;
    end
    last_c = (cnt_q == CNT_W'(IN_W - 1));
  end

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    thr_d      = thr_q;
    dec_d      = dec_q;
    blank_d    = blank_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (iValid) begin
          bin_d      = op_mag_c;
          bcd_d      = '0;
          cnt_d      = '0;
          neg_pend_d = op_neg_c;
          thr_d      = op_ge_c;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_sh_c;
        bin_d = bin_sh_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          dec_d   = dec_new_c;
          blank_d = blank_new_c;
          neg_d   = neg_pend_q;
          ovf_d   = thr_q | upper_nz_c | carry_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // Synchronous reset wins over any handshake in the same cycle.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      thr_q      <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      dec_q      <= '0;
      blank_q    <= BLANK_RST;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      thr_q      <= thr_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      dec_q      <= dec_d;
      blank_q    <= blank_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oDec   = dec_q;
  assign oBlank = blank_q;
  assign oNeg   = neg_q;
  assign oOvf   = ovf_q;

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter IN_W, default 32: binary input width, legal range 4..64.
REQ-002 Parameter DIGITS, default 2: number of BCD digits presented, legal range 1..20.
REQ-003 Parameter SIGNED_EN, default 1: when 0, iSigned is ignored and treated as 0.
REQ-004 iClk  input  1  sole clock; all state changes on its rising edge.
REQ-005 iRst  input  1  reset; synchronous and active-high.
REQ-006 iValid  input  1  request to convert iBin.
REQ-007 iBin  input  IN_W  binary value to convert.
REQ-008 iSigned  input  1  treat iBin as two's complement.
REQ-009 oReady  output  1  block can accept a request.
REQ-010 oValid  output  1  result held on the outputs.
REQ-011 iReady  input  1  consumer takes the result.
REQ-012 oDec  output  4*DIGITS  BCD digits; digit 0 (ones) in bits [3:0].
REQ-013 oBlank  output  DIGITS  leading-zero blanking mask, one bit per digit.
REQ-014 oNeg  output  1  result is negative.
REQ-015 oOvf  output  1  magnitude is greater than or equal to 10^DIGITS.

Function
REQ-016 States: IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 oReady shall be 1 only in IDLE; oValid shall be 1 only in DONE.
REQ-018 Accept: IDLE and iValid=1 at an edge -> capture operand, go to SHIFT, clear the shift counter.
  - iBin and iSigned are sampled only at that edge.
REQ-019 Operand magnitude: if iSigned=1 and iBin[IN_W-1]=1, magnitude = two's-complement negation of iBin, as an unsigned IN_W-bit value; otherwise magnitude = iBin.
  - The most negative value gives 2^(IN_W-1) exactly.
REQ-020 Conversion uses the double-dabble (shift-add-3) algorithm over INT_DIGITS = floor(3*IN_W/10)+1 internal digits.
  - Each SHIFT cycle: every internal digit >= 5 gets +3, then the {BCD, binary} register shifts left 1.
REQ-021 SHIFT lasts exactly IN_W cycles, then goes to DONE.
  - oValid rises exactly IN_W edges after the accept edge.
REQ-022 oDec = magnitude mod 10^DIGITS, i.e. the lowest DIGITS internal digits.
REQ-023 oOvf = 1 iff magnitude >= 10^DIGITS, or internal digits above DIGITS are nonzero.
  - Always 0 when DIGITS >= INT_DIGITS.
REQ-024 oNeg = 1 iff the operand was negative per REQ-019; a zero result has oNeg=0.
REQ-025 oBlank[i] = 1 iff i > 0 and digits i..DIGITS-1 of oDec are all zero; oBlank[0] is always 0.
  - Mask is computed from truncated oDec even when oOvf=1.
REQ-026 DONE holds oDec, oBlank, oNeg and oOvf stable while iReady=0, with no timeout.
REQ-027 DONE with iReady=1 at an edge -> IDLE.
  - No same-cycle re-accept.
  - Minimum accept-to-accept spacing is IN_W+2 cycles.
REQ-028 iValid in SHIFT or DONE is ignored; no request is queued.
REQ-029 In IDLE, outputs hold the last completed result, or zeros after reset.

Reset
REQ-030 iRst=1 at an edge forces IDLE from any state, including mid-SHIFT or DONE; the aborted conversion is discarded.
REQ-031 Reset values: oReady=1, oValid=0, oDec=0, oBlank=all-ones except bit 0, oNeg=0, oOvf=0; the internal shift register and counter are zero.
REQ-032 iRst has priority over every handshake event in the same cycle.

Structure
REQ-033 Package bin_bcd_pkg holds:
  - the state enumeration;
  - constant function int_digits(IN_W);
  - constant function pow10(DIGITS), used for the overflow threshold.
REQ-034 Sub-module bcd_digit_adj: combinational 4-bit add-3-if->=5 cell, instantiated once per internal digit.
REQ-035 Shift counter width is clog2(IN_W+1); no divider or modulo operators in the datapath.

Verification
REQ-036 Reset mid-SHIFT: iRst at cycle 10 after accept -> next edge oReady=1, oValid=0, oDec=0x00.
REQ-037 IN_W=32, DIGITS=2, iBin=37, iSigned=0 -> oValid exactly 32 edges after accept, oDec=0x37, oBlank=00, oOvf=0, oNeg=0.
REQ-038 iBin=123, DIGITS=2 -> oDec=0x23, oOvf=1.
  - iBin=5 -> oDec=0x05, oBlank=10.
  - iBin=0 -> oDec=0x00, oBlank=10.
REQ-039 iBin=0xFFFFFFE7:
  - iSigned=1 -> oDec=0x25, oNeg=1, oOvf=0.
  - iSigned=0 -> 4294967271 -> oDec=0x71, oOvf=1, oNeg=0.
  - iBin=0x80000000, iSigned=1 -> oDec=0x48, oNeg=1, oOvf=1.
REQ-040 Backpressure: iReady=0 for 5 cycles in DONE -> outputs stable, oValid=1.
  - iValid asserted during SHIFT is not accepted.
  - iReady=1 -> IDLE next edge; back-to-back requests spaced IN_W+2 cycles.
REQ-041 Exhaustive sweep with IN_W=10, DIGITS=4 over all 1024 unsigned values, compared against a reference model; oOvf never set.
